// File: rtl/ram_pkg.sv
// -----------------------------------------------------------------------------
// ram_pkg
// Shared definitions for the data-RAM write path: default geometry shared with
// RAM_DUAL_READ_PORT and the state encoding of the block writer FSM.
// No ports (package).
// -----------------------------------------------------------------------------
package ram_pkg;

    // Default RAM geometry. RAM_MEM_SIZE is the highest valid index, so the
    // RAM holds RAM_MEM_SIZE+1 words.
    localparam int RAM_DATA_WIDTH = 16;
    localparam int RAM_MEM_SIZE   = 8;
    localparam int RAM_ADDR_WIDTH = 4;

    // Writer FSM state encoding.
    localparam logic [1:0] ENC_IDLE   = 2'b00;
    localparam logic [1:0] ENC_LOAD   = 2'b01;
    localparam logic [1:0] ENC_CLEAR  = 2'b10;
    localparam logic [1:0] ENC_FINISH = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = ENC_IDLE,
        ST_LOAD   = ENC_LOAD,
        ST_CLEAR  = ENC_CLEAR,
        ST_FINISH = ENC_FINISH
    } state_t;

endpackage

// File: rtl/ram_addr_wrap_counter.sv
// -----------------------------------------------------------------------------
// ram_addr_wrap_counter
// Loadable RAM address counter. A load value above MEM_SIZE is clamped to 0;
// advancing from MEM_SIZE wraps to 0 (modulo MEM_SIZE+1, not 2^ADDR_WIDTH).
// Load has priority over advance.
//
// Ports:
//   Clock      in   rising-edge clock
//   Reset      in   asynchronous active-low reset (address -> 0)
//   iLoad      in   load iLoadValue (clamped) on the next edge
//   iLoadValue in   start address
//   iAdvance   in   step to the next address on the next edge
//   oAddress   out  current address (registered)
// -----------------------------------------------------------------------------
module ram_addr_wrap_counter
    import ram_pkg::*;
#(
    parameter int MEM_SIZE   = RAM_MEM_SIZE,
    parameter int ADDR_WIDTH = RAM_ADDR_WIDTH
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  iLoad,
    input  logic [ADDR_WIDTH-1:0] iLoadValue,
    input  logic                  iAdvance,
    output logic [ADDR_WIDTH-1:0] oAddress
);

    localparam logic [ADDR_WIDTH-1:0] LP_LAST = ADDR_WIDTH'(MEM_SIZE);

    logic [ADDR_WIDTH-1:0] r_address;
    logic [ADDR_WIDTH-1:0] w_address_next;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_address_next = r_address;
        if (iLoad) begin
            w_address_next = (iLoadValue > LP_LAST) ? '0 : iLoadValue;
        end else if (iAdvance) begin
            w_address_next = (r_address == LP_LAST) ? '0 : r_address + 1'b1;
        end
    end

    // NOTE: clocked state uses non-blocking (<=) so every register samples
    // the pre-edge values regardless of process ordering.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_address <= '0;
        end else begin
            r_address <= w_address_next;
        end
    end

    assign oAddress = r_address;

endmodule

// File: rtl/ram_block_writer.sv
// -----------------------------------------------------------------------------
// ram_block_writer
// Write-side sequencer for RAM_DUAL_READ_PORT. Loads a block of words from a
// valid/ready stream into consecutive RAM addresses (LOAD) or zero-fills a
// range (CLEAR). Addresses wrap at MEM_SIZE. All outputs are registered; a
// write appears on the RAM port one cycle after its handshake, and oDone
// pulses one cycle after the last write.
//
// Ports:
//   Clock          in   rising-edge clock
//   Reset          in   asynchronous active-low reset
//   iStart         in   start request, sampled only in IDLE
//   iClear         in   1 = zero-fill, 0 = load from stream (with iStart)
//   iBaseAddress   in   first address written (clamped to 0 if > MEM_SIZE)
//   iCount         in   number of words to write, 0 legal
//   iValid/iData   in   upstream stream
//   oReady         out  stream word accepted this cycle when iValid=1
//   oWriteEnable   out  RAM iWriteEnable
//   oWriteAddress  out  RAM iWriteAddress
//   oDataOut       out  RAM iDataIn
//   oBusy          out  operation in progress
//   oDone          out  one-cycle completion pulse
//
// Optional build macro RAM_BLOCK_WRITER_READBACK_EN adds:
//   oReadAddress   out  address for one RAM read port (previous write)
//   iReadData      in   data from that read port
//   oMismatch      out  sticky readback-compare failure
// and holds oBusy / delays oDone until the last readback compare.
// -----------------------------------------------------------------------------
module ram_block_writer
    import ram_pkg::*;
#(
    parameter int DATA_WIDTH         = RAM_DATA_WIDTH,
    parameter int MEM_SIZE           = RAM_MEM_SIZE,
    parameter int ADDR_WIDTH_MAX_USE = RAM_ADDR_WIDTH
) (
    input  logic                          Clock,
    input  logic                          Reset,
    input  logic                          iStart,
    input  logic                          iClear,
    input  logic [ADDR_WIDTH_MAX_USE-1:0] iBaseAddress,
    input  logic [ADDR_WIDTH_MAX_USE:0]   iCount,
    input  logic                          iValid,
    input  logic [DATA_WIDTH-1:0]         iData,
    output logic                          oReady,
    output logic                          oWriteEnable,
    output logic [ADDR_WIDTH_MAX_USE-1:0] oWriteAddress,
    output logic [DATA_WIDTH-1:0]         oDataOut,
    output logic                          oBusy,
    output logic                          oDone
`ifdef RAM_BLOCK_WRITER_READBACK_EN
    ,
    output logic [ADDR_WIDTH_MAX_USE-1:0] oReadAddress,
    input  logic [DATA_WIDTH-1:0]         iReadData,
    output logic                          oMismatch
`endif
);

    localparam int                CW           = ADDR_WIDTH_MAX_USE + 1;
    localparam logic [CW-1:0]     LP_COUNT_ONE = CW'(1);

    state_t                          r_state;
    state_t                          w_state_next;
    logic [CW-1:0]                   r_remaining;
    logic [CW-1:0]                   w_remaining_next;

    logic                            r_ready;
    logic                            r_write_enable;
    logic [ADDR_WIDTH_MAX_USE-1:0]   r_write_address;
    logic [DATA_WIDTH-1:0]           r_data_out;
    logic                            r_busy;
    logic                            r_done;

    logic                            w_ready_next;
    logic                            w_write_enable_next;
    logic [ADDR_WIDTH_MAX_USE-1:0]   w_write_address_next;
    logic [DATA_WIDTH-1:0]           w_data_out_next;
    logic                            w_busy_next;
    logic                            w_done_next;

    logic                            w_addr_load;
    logic                            w_addr_advance;
    logic [ADDR_WIDTH_MAX_USE-1:0]   w_addr;
    logic                            w_transfer;
    logic                            w_drain_pending;

    ram_addr_wrap_counter #(
        .MEM_SIZE   (MEM_SIZE),
        .ADDR_WIDTH (ADDR_WIDTH_MAX_USE)
    ) u_addr_counter (
        .Clock      (Clock),
        .Reset      (Reset),
        .iLoad      (w_addr_load),
        .iLoadValue (iBaseAddress),
        .iAdvance   (w_addr_advance),
        .oAddress   (w_addr)
    );

    // oReady is registered, so the handshake uses the value the upstream sees.
    assign w_transfer = r_ready && iValid;

    // Next-state and next-output logic.
    always_comb begin
        w_state_next         = r_state;
        w_remaining_next     = r_remaining;
        w_write_enable_next  = 1'b0;
        w_write_address_next = r_write_address;
        w_data_out_next      = r_data_out;
        w_done_next          = 1'b0;
        w_addr_load          = 1'b0;
        w_addr_advance       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (iStart) begin
                    w_addr_load      = 1'b1;
                    w_remaining_next = iCount;
                    if (iCount == '0) begin
                        w_state_next = ST_FINISH;
                    end else if (iClear) begin
                        w_state_next = ST_CLEAR;
                    end else begin
                        w_state_next = ST_LOAD;
                    end
                end
            end

            ST_LOAD: begin
                if (w_transfer) begin
                    w_write_enable_next  = 1'b1;
                    w_write_address_next = w_addr;
                    w_data_out_next      = iData;
                    w_addr_advance       = 1'b1;
                    w_remaining_next     = r_remaining - LP_COUNT_ONE;
                    if (r_remaining == LP_COUNT_ONE) begin
                        w_state_next = ST_FINISH;
                    end
                end
            end

            ST_CLEAR: begin
                w_write_enable_next  = 1'b1;
                w_write_address_next = w_addr;
                w_data_out_next      = '0;
                w_addr_advance       = 1'b1;
                w_remaining_next     = r_remaining - LP_COUNT_ONE;
                if (r_remaining == LP_COUNT_ONE) begin
                    w_state_next = ST_FINISH;
                end
            end

            ST_FINISH: begin
                // The first FINISH cycle shows the last write on the RAM port;
                // oDone follows on the way out.
                if (!w_drain_pending) begin
                    w_state_next = ST_IDLE;
                    w_done_next  = 1'b1;
                end
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        w_ready_next = (w_state_next == ST_LOAD);
        w_busy_next  = (w_state_next != ST_IDLE);
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_remaining     <= '0;
            r_ready         <= 1'b0;
            r_write_enable  <= 1'b0;
            r_write_address <= '0;
            r_data_out      <= '0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
        end else begin
            r_remaining     <= w_remaining_next;
            r_ready         <= w_ready_next;
            r_write_enable  <= w_write_enable_next;
            r_write_address <= w_write_address_next;
            r_data_out      <= w_data_out_next;
            r_busy          <= w_busy_next;
            r_done          <= w_done_next;
        end
    end

    assign oReady        = r_ready;
    assign oWriteEnable  = r_write_enable;
    assign oWriteAddress = r_write_address;
    assign oDataOut      = r_data_out;
    assign oBusy         = r_busy;
    assign oDone         = r_done;

`ifdef RAM_BLOCK_WRITER_READBACK_EN
    // Readback pipeline: the cycle after a write its address is presented to
    // the RAM read port; the cycle after that the returned word is compared.
    logic                          r_rb_valid;
    logic [ADDR_WIDTH_MAX_USE-1:0] r_read_address;
    logic [DATA_WIDTH-1:0]         r_rb_data;
    logic                          r_cmp_valid;
    logic [DATA_WIDTH-1:0]         r_cmp_data;
    logic                          r_mismatch;
    logic                          r_drain_seen;

    // FINISH is held one extra cycle so oDone lands in the compare cycle of
    // the last word, two cycles after that write.
    assign w_drain_pending = !r_drain_seen;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_rb_valid     <= 1'b0;
            r_read_address <= '0;
            r_rb_data      <= '0;
            r_cmp_valid    <= 1'b0;
            r_cmp_data     <= '0;
            r_mismatch     <= 1'b0;
            r_drain_seen   <= 1'b0;
        end else begin
            r_rb_valid   <= r_write_enable;
            r_cmp_valid  <= r_rb_valid;
            r_cmp_data   <= r_rb_data;
            r_drain_seen <= (r_state == ST_FINISH);
            if (r_write_enable) begin
                r_read_address <= r_write_address;
                r_rb_data      <= r_data_out;
            end
            // A newly accepted operation starts with a clean flag.
            if (r_state == ST_IDLE && iStart) begin
                r_mismatch <= 1'b0;
            end else if (r_cmp_valid && (iReadData != r_cmp_data)) begin
                r_mismatch <= 1'b1;
            end
        end
    end

    assign oReadAddress = r_read_address;
    assign oMismatch    = r_mismatch;
`else
    assign w_drain_pending = 1'b0;
`endif

endmodule

// File: tb/tb_ram_block_writer.sv
// -----------------------------------------------------------------------------
// tb_ram_block_writer
// Directed, table-driven bench for ram_block_writer with MEM_SIZE=8. Each
// table row holds the inputs applied for one clock and the registered outputs
// expected after that clock. A small RAM model collects the writes.
// -----------------------------------------------------------------------------
module tb_ram_block_writer;

    logic        Clock;
    logic        Reset;
    logic        iStart;
    logic        iClear;
    logic [3:0]  iBaseAddress;
    logic [4:0]  iCount;
    logic        iValid;
    logic [15:0] iData;
    logic        oReady;
    logic        oWriteEnable;
    logic [3:0]  oWriteAddress;
    logic [15:0] oDataOut;
    logic        oBusy;
    logic        oDone;
`ifdef RAM_BLOCK_WRITER_READBACK_EN
    logic [3:0]  oReadAddress;
    logic [15:0] iReadData;
    logic        oMismatch;
    logic        corrupt_en;
    logic [3:0]  corrupt_addr;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [15:0] mem [0:15];

    ram_block_writer #(
        .DATA_WIDTH         (16),
        .MEM_SIZE           (8),
        .ADDR_WIDTH_MAX_USE (4)
    ) dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .iStart        (iStart),
        .iClear        (iClear),
        .iBaseAddress  (iBaseAddress),
        .iCount        (iCount),
        .iValid        (iValid),
        .iData         (iData),
        .oReady        (oReady),
        .oWriteEnable  (oWriteEnable),
        .oWriteAddress (oWriteAddress),
        .oDataOut      (oDataOut),
        .oBusy         (oBusy),
        .oDone         (oDone)
`ifdef RAM_BLOCK_WRITER_READBACK_EN
        ,
        .oReadAddress  (oReadAddress),
        .iReadData     (iReadData),
        .oMismatch     (oMismatch)
`endif
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

`ifdef RAM_BLOCK_WRITER_READBACK_EN
    // Synchronous-read RAM model with an optional corrupted location.
    always @(posedge Clock) begin
        iReadData <= mem[oReadAddress] ^
                     ((corrupt_en && oReadAddress == corrupt_addr) ? 16'hFFFF : 16'h0000);
    end
`endif

    typedef struct {
        logic        start;
        logic        clear;
        logic [3:0]  base;
        logic [4:0]  count;
        logic        valid;
        logic [15:0] data;
        logic        ready;
        logic        we;
        logic [3:0]  wa;
        logic [15:0] dout;
        logic        busy;
        logic        done;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic s, input logic c, input logic [3:0] b,
                       input logic [4:0] n, input logic v, input logic [15:0] d,
                       input logic rdy, input logic we, input logic [3:0] wa,
                       input logic [15:0] dout, input logic busy, input logic done);
        vec_t r;
        r.start = s; r.clear = c; r.base = b; r.count = n; r.valid = v; r.data = d;
        r.ready = rdy; r.we = we; r.wa = wa; r.dout = dout; r.busy = busy; r.done = done;
        vecs.push_back(r);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: outputs are sampled 1 time unit after the rising edge and any
    // RAM write visible then is committed to the model.
    task automatic step();
        @(posedge Clock);
        #1;
        cyc++;
        if (oWriteEnable === 1'b1) mem[oWriteAddress] = oDataOut;
    endtask

    task automatic drive(input logic s, input logic c, input logic [3:0] b,
                         input logic [4:0] n, input logic v, input logic [15:0] d);
        iStart = s; iClear = c; iBaseAddress = b; iCount = n; iValid = v; iData = d;
    endtask

    // Status bits, plus address/data only where a write is expected.
    function automatic logic [63:0] pack(input logic rdy, input logic we, input logic busy,
                                         input logic done, input logic [3:0] wa,
                                         input logic [15:0] d, input logic show);
        return {40'h0, rdy, we, busy, done, (show ? {wa, d} : 20'h0)};
    endfunction

    task automatic check_outputs(input string name, input vec_t e);
        check(name,
              pack(oReady, oWriteEnable, oBusy, oDone, oWriteAddress, oDataOut, e.we),
              pack(e.ready, e.we, e.busy, e.done, e.wa, e.dout, e.we));
    endtask

    task automatic do_reset();
        Reset = 1'b0;
        drive(0, 0, 0, 0, 0, 16'h0);
        @(posedge Clock);
        @(posedge Clock);
        #1;
        check("reset_outputs",
              {58'h0, oReady, oWriteEnable, oBusy, oDone, |oWriteAddress, |oDataOut}, 64'h0);
        Reset = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 16'hFFFF;
`ifdef RAM_BLOCK_WRITER_READBACK_EN
        corrupt_en   = 1'b0;
        corrupt_addr = 4'd1;
`endif
        do_reset();

`ifndef RAM_BLOCK_WRITER_READBACK_EN
        // add(start, clear, base, count, valid, data,  ready, we, wa, dout, busy, done)
        // Clear base=0 count=9: iValid toggles, stray iStart pulses ignored.
        add(1, 1, 4'd0, 5'd9, 1, 16'hDEAD,  0, 0, 4'd0, 16'h0, 1, 0);
        for (int k = 0; k < 9; k++)
            add((k == 4), 0, 4'd5, 5'd2, k[0], 16'hBEEF,  0, 1, 4'(k), 16'h0000, 1, 0);
        add(0, 0, 4'd0, 5'd0, 1, 16'h0,  0, 0, 4'd0, 16'h0, 0, 1);
        // Wrap: base=7 count=4 -> 7,8,0,1.
        add(1, 0, 4'd7, 5'd4, 0, 16'h0,     1, 0, 4'd0, 16'h0,    1, 0);
        add(0, 0, 4'd0, 5'd0, 1, 16'h0011,  1, 1, 4'd7, 16'h0011, 1, 0);
        add(0, 0, 4'd0, 5'd0, 1, 16'h0012,  1, 1, 4'd8, 16'h0012, 1, 0);
        add(0, 0, 4'd0, 5'd0, 1, 16'h0013,  1, 1, 4'd0, 16'h0013, 1, 0);
        add(0, 0, 4'd0, 5'd0, 1, 16'h0014,  0, 1, 4'd1, 16'h0014, 1, 0);
        add(0, 0, 4'd0, 5'd0, 0, 16'h0,     0, 0, 4'd0, 16'h0,    0, 1);
        // Count=0: FINISH then oDone, no write.
        add(1, 0, 4'd3, 5'd0, 1, 16'h5555,  0, 0, 4'd0, 16'h0, 1, 0);
        add(0, 0, 4'd0, 5'd0, 0, 16'h0,     0, 0, 4'd0, 16'h0, 0, 1);
        add(0, 0, 4'd0, 5'd0, 0, 16'h0,     0, 0, 4'd0, 16'h0, 0, 0);
        // Base above MEM_SIZE clamps to 0.
        add(1, 1, 4'd12, 5'd2, 0, 16'h0,  0, 0, 4'd0, 16'h0, 1, 0);
        add(0, 0, 4'd0,  5'd0, 0, 16'h0,  0, 1, 4'd0, 16'h0, 1, 0);
        add(0, 0, 4'd0,  5'd0, 0, 16'h0,  0, 1, 4'd1, 16'h0, 1, 0);
        add(0, 0, 4'd0,  5'd0, 0, 16'h0,  0, 0, 4'd0, 16'h0, 0, 1);
        // Backpressure: iValid 1,0,0,1,1; iStart while busy and in FINISH ignored.
        add(1, 0, 4'd5, 5'd3, 0, 16'h0,     1, 0, 4'd0, 16'h0,    1, 0);
        add(0, 0, 4'd0, 5'd0, 1, 16'h0B01,  1, 1, 4'd5, 16'h0B01, 1, 0);
        add(1, 1, 4'd0, 5'd2, 0, 16'h9999,  1, 0, 4'd0, 16'h0,    1, 0);
        add(0, 0, 4'd0, 5'd0, 0, 16'h9999,  1, 0, 4'd0, 16'h0,    1, 0);
        add(0, 0, 4'd0, 5'd0, 1, 16'h0B02,  1, 1, 4'd6, 16'h0B02, 1, 0);
        add(0, 0, 4'd0, 5'd0, 1, 16'h0B03,  0, 1, 4'd7, 16'h0B03, 1, 0);
        add(1, 1, 4'd0, 5'd2, 0, 16'h0,     0, 0, 4'd0, 16'h0,    0, 1);
        add(0, 0, 4'd0, 5'd0, 0, 16'h0,     0, 0, 4'd0, 16'h0,    0, 0);
        // Load base=2 count=3 with iValid held high.
        add(1, 0, 4'd2, 5'd3, 1, 16'h00A1,  1, 0, 4'd0, 16'h0,    1, 0);
        add(0, 0, 4'd0, 5'd0, 1, 16'h00A1,  1, 1, 4'd2, 16'h00A1, 1, 0);
        add(0, 0, 4'd0, 5'd0, 1, 16'h00A2,  1, 1, 4'd3, 16'h00A2, 1, 0);
        add(0, 0, 4'd0, 5'd0, 1, 16'h00A3,  0, 1, 4'd4, 16'h00A3, 1, 0);
        add(0, 0, 4'd0, 5'd0, 1, 16'h00A3,  0, 0, 4'd0, 16'h0,    0, 1);
        add(0, 0, 4'd0, 5'd0, 0, 16'h0,     0, 0, 4'd0, 16'h0,    0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].start, vecs[i].clear, vecs[i].base, vecs[i].count,
                  vecs[i].valid, vecs[i].data);
            step();
            check_outputs($sformatf("row%0d", i), vecs[i]);
        end

        // RAM contents after all table operations.
        begin
            logic [15:0] exp_mem [0:8];
            exp_mem = '{16'h0000, 16'h0000, 16'h00A1, 16'h00A2, 16'h00A3,
                        16'h0B01, 16'h0B02, 16'h0B03, 16'h0012};
            for (int a = 0; a < 9; a++)
                check($sformatf("mem%0d", a), {48'h0, mem[a]}, {48'h0, exp_mem[a]});
        end

        // Reset asserted while the 2nd word of a 4-word load is on the port.
        drive(1, 0, 4'd0, 5'd4, 0, 16'h0);
        step();
        drive(0, 0, 4'd0, 5'd0, 1, 16'h00C1);
        step();
        drive(0, 0, 4'd0, 5'd0, 1, 16'h00C2);
        step();
        check("mid_second_write", {44'h0, oWriteEnable, oWriteAddress, oDataOut},
              {44'h0, 1'b1, 4'd1, 16'h00C2});
        #2;
        Reset = 1'b0;
        #1;
        check("async_reset", {60'h0, oWriteEnable, oBusy, oReady, oDone}, 64'h0);
        iValid = 1'b0;
        @(posedge Clock);
        #1;
        Reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("no_done_%0d", k), {62'h0, oDone, oWriteEnable}, 64'h0);
        end
        drive(1, 0, 4'd3, 5'd1, 0, 16'h0);
        step();
        check("restart_load", {62'h0, oReady, oBusy}, {62'h0, 1'b1, 1'b1});
        drive(0, 0, 4'd0, 5'd0, 1, 16'h00D1);
        step();
        check("restart_write", {43'h0, oReady, oWriteEnable, oWriteAddress, oDataOut},
              {43'h0, 1'b0, 1'b1, 4'd3, 16'h00D1});
        drive(0, 0, 4'd0, 5'd0, 0, 16'h0);
        step();
        check("restart_done", {62'h0, oDone, oBusy}, {62'h0, 1'b1, 1'b0});
`else
        // Readback build: corrupt address 1 of a 3-word load at base 0.
        begin
            int last_we;
            int done_at;
            last_we = -1;
            done_at = -1;
            check("rb_reset_mismatch", {63'h0, oMismatch}, 64'h0);
            corrupt_en = 1'b1;
            drive(1, 0, 4'd0, 5'd3, 0, 16'h0);
            step();
            for (int k = 0; k < 3; k++) begin
                drive(0, 0, 4'd0, 5'd0, 1, 16'h00E1 + 16'(k));
                step();
                if (oWriteEnable) last_we = cyc;
            end
            drive(0, 0, 4'd0, 5'd0, 0, 16'h0);
            for (int k = 0; k < 10 && done_at < 0; k++) begin
                step();
                if (oWriteEnable) last_we = cyc;
                if (oDone) done_at = cyc;
            end
            check("rb_done_seen", {63'h0, (done_at >= 0)}, 64'h1);
            check("rb_done_delay", 64'(done_at - last_we), 64'd2);
            step();
            check("rb_mismatch_set", {63'h0, oMismatch}, 64'h1);
            step();
            step();
            check("rb_mismatch_sticky", {63'h0, oMismatch}, 64'h1);
            corrupt_en = 1'b0;
            drive(1, 1, 4'd0, 5'd1, 0, 16'h0);
            step();
            drive(0, 0, 4'd0, 5'd0, 0, 16'h0);
            check("rb_mismatch_clear", {63'h0, oMismatch}, 64'h0);
            for (int k = 0; k < 6; k++) step();
            check("rb_clean_pass", {62'h0, oMismatch, oBusy}, 64'h0);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
